pwm_amp_sequencer: RTL and testbench
====================================

Name: pwm_amp_sequencer

Overview:
- Parametrised successor to the fixed amplifier-enable tie-off: drives NUM_CH active-low amplifier shutdown pins (audio, tape, extra PWM channels) from a sequenced per-channel FSM.
- Provides global power-up hold-off, staggered channel wake (inrush/pop control), settle time before PWM data is gated through, idle auto-shutdown with activity re-arm, and a global force-off.
- Sits between the audio mixer/PWM DACs and the board amplifier SD pins.

Parameters:
- NUM_CH, 2, number of amplifier channels (1..8)
- CNT_W, 20, width of all timing counters
- POWERUP_CYCLES, 65536, cycles after reset release before any channel may wake
- STAGGER_CYCLES, 4096, minimum cycles between successive channel wake starts
- SETTLE_CYCLES, 8192, cycles from sd high to ch_ready high
- DRAIN_CYCLES, 1024, cycles from ch_ready low to sd low on idle shutdown
- IDLE_CYCLES, 0, cycles without activity before idle shutdown; 0 disables idle shutdown

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ch_en_req  in  NUM_CH  per-channel enable request, level
- ch_activity  in  NUM_CH  per-channel single-cycle pulse on a non-silent sample
- force_off  in  1  level; forces all channels off
- amp_sd  out  NUM_CH  amplifier shutdown pins, 1 = amplifier running
- ch_ready  out  NUM_CH  1 = PWM data may be driven to the channel
- powerup_done  out  1  global hold-off elapsed

Behaviour:
- Reset, asynchronous active-low on rst_n: amp_sd=0, ch_ready=0, powerup_done=0, every channel OFF, armed=1, all counters 0.
- Reset asserted mid-operation drops all outputs to 0 immediately, with no drain sequence.
- Power-up counter: counts from rst_n release. powerup_done rises in the cycle after exactly POWERUP_CYCLES counted, then stays 1 until reset.
- Per-channel FSM states: OFF, WAKE, ON, DRAIN.
  - OFF: amp_sd=0, ready=0. Goes to WAKE when powerup_done & ch_en_req & armed & ~force_off & stagger grant.
  - WAKE: amp_sd=1, ready=0, counts SETTLE_CYCLES. Goes to ON when the count is done. Goes to OFF immediately if ch_en_req drops or force_off is set.
  - ON: amp_sd=1, ready=1. Goes to DRAIN if ch_en_req drops, or if idle timeout fires (IDLE_CYCLES≠0). Goes to OFF directly on force_off.
  - DRAIN: amp_sd=1, ready=0, counts DRAIN_CYCLES, then goes to OFF. force_off goes to OFF immediately. ch_en_req returning during DRAIN does not abort; the channel re-wakes from OFF.
- All output changes are registered and appear one cycle after the state transition decision.
- Stagger arbiter:
  - At most one OFF→WAKE transition per cycle; the lowest index eligible channel wins.
  - After a grant, no further grant is issued for STAGGER_CYCLES cycles.
  - The first grant after powerup_done has no wait.
- Idle timer, per channel:
  - Runs only in ON; reset to 0 by ch_activity or on entering ON.
  - Timeout when it reaches IDLE_CYCLES: the channel clears armed and goes to DRAIN.
- armed:
  - Set by ch_activity in any state; set on reset.
  - A simultaneous timeout and activity pulse: activity wins, the timer resets and there is no shutdown.
  - An OFF channel with armed=0 and ch_en_req=1 waits for an activity pulse, then requests a grant.
- Counters saturate and never wrap. A parameter value of 0 for SETTLE or DRAIN means the transition is taken the next cycle.
- force_off and ch_en_req are used as-is; synchronisation is the caller's responsibility.

Decomposition:
- Shared package pwm_amp_pkg:
  - 2-bit state encodings ST_OFF, ST_WAKE, ST_ON, ST_DRAIN.
  - Default timing constants.
- Sub-module pwm_amp_channel:
  - One FSM, settle/drain/idle counter and armed flag.
  - Instantiated NUM_CH times via generate.
- The top level holds the power-up counter, stagger arbiter and counter, and output registers.

Test Plan:
All cases use NUM_CH=2, POWERUP=16, STAGGER=4, SETTLE=8, DRAIN=3, IDLE=20 unless stated.
- Reset values: hold rst_n=0 with ch_en_req=2'b11 -> amp_sd=0, ch_ready=0, powerup_done=0. Assert rst_n low asynchronously mid-ON -> outputs 0 without waiting for a clock edge.
- Power-up and stagger: ch_en_req=2'b11 from reset ->
  - powerup_done at cycle 16.
  - amp_sd[0] rises one cycle later; amp_sd[1] rises 4 cycles after amp_sd[0].
  - Each ch_ready rises 8 cycles after its amp_sd.
- Request drop mid-WAKE: ch0 in WAKE, drop ch_en_req[0] at settle count 5 -> amp_sd[0]=0 next cycle, ch_ready[0] never rises.
- Idle shutdown and re-arm: ch0 ON with no activity ->
  - ch_ready[0] falls after 20 cycles; amp_sd[0] falls 3 cycles later.
  - A ch_activity[0] pulse then re-wakes ch0 (settle 8 again).
- Simultaneous timeout and activity: activity pulse on the exact timeout cycle -> ch_ready stays 1 and the idle timer restarts.
- force_off: both channels ON, pulse force_off for 1 cycle -> both amp_sd and ch_ready go to 0 next cycle, with no DRAIN. On release, channels re-wake staggered by 4.

Source files
------------

// File: rtl/pwm_amp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_amp_pkg                                               |
// | Purpose  : Shared state encoding, default timing and count helper    |
// |            for the amplifier shutdown sequencer.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pwm_amp_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } ch_state_e;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_CNT_W          = 20;
  localparam int DEF_POWERUP_CYCLES = 65536;
  localparam int DEF_STAGGER_CYCLES = 4096;
  localparam int DEF_SETTLE_CYCLES  = 8192;
  localparam int DEF_DRAIN_CYCLES   = 1024;
  localparam int DEF_IDLE_CYCLES    = 0;

  // True when the cycle being counted now completes 'limit' cycles.
  // A limit of 0 behaves like 1, so the phase always lasts one cycle.
  function automatic logic limit_reached(input logic [31:0] cnt, input logic [31:0] limit);
    return ({1'b0, cnt} + 33'd1) >= {1'b0, limit};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_amp_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_amp_channel                                           |
// | Purpose  : One amplifier channel: OFF/WAKE/ON/DRAIN sequencing,      |
// |            shared settle/drain/idle counter and activity arm flag.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pwm_amp_channel
  import pwm_amp_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int IDLE_CYCLES   = DEF_IDLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en_req,
  input  logic i_activity,
  input  logic i_force_off,
  input  logic i_powerup_done,
  input  logic i_grant,
  output logic o_wake_req,
  output logic o_sd_d,
  output logic o_ready_d
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             armed_q, armed_d;
  logic [31:0]      cnt_ext;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_ext = 32'(cnt_q);

  // Channel asks the arbiter for a wake slot only from OFF with all gates open.
  assign o_wake_req = (state_q == ST_OFF) & i_en_req & armed_q & i_powerup_done & ~i_force_off;

  // Next state, counter and arm flag; the counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    armed_d = armed_q | i_activity;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (i_grant) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (i_force_off || !i_en_req) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (limit_reached(cnt_ext, SETTLE_CYCLES)) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (i_force_off) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (!i_en_req) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (i_activity) begin
          // Activity beats a coincident timeout and restarts the idle window.
          cnt_d = '0;
        end else if ((IDLE_CYCLES != 0) && limit_reached(cnt_ext, IDLE_CYCLES)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (i_force_off || limit_reached(cnt_ext, DRAIN_CYCLES)) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin levels follow the next state so the top registers them alongside it.
  assign o_sd_d    = (state_d != ST_OFF);
  assign o_ready_d = (state_d == ST_ON);

  // Channel state registers; reset leaves the channel OFF and armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_amp_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_amp_sequencer                                         |
// | Purpose  : Drives NUM_CH amplifier SD pins with power-up hold-off,   |
// |            staggered wake, settle gating and idle auto-shutdown.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pwm_amp_sequencer
  import pwm_amp_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int POWERUP_CYCLES = DEF_POWERUP_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int IDLE_CYCLES    = DEF_IDLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en_req,
  input  logic [NUM_CH-1:0] ch_activity,
  input  logic              force_off,
  output logic [NUM_CH-1:0] amp_sd,
  output logic [NUM_CH-1:0] ch_ready,
  output logic              powerup_done
);

  // Value loaded after a grant so the next grant lands STAGGER_CYCLES later.
  localparam logic [CNT_W-1:0] C_STAG_LOAD =
    (STAGGER_CYCLES == 0) ? '0 : CNT_W'(STAGGER_CYCLES - 1);

  logic [CNT_W-1:0]  pu_cnt_q, pu_cnt_d;
  logic              powerup_done_q, powerup_done_d;
  logic [CNT_W-1:0]  stag_cnt_q, stag_cnt_d;
  logic [NUM_CH-1:0] amp_sd_q, ch_ready_q;
  logic [NUM_CH-1:0] wake_req, grant, sd_d, ready_d;

  // Power-up hold-off: count from reset release, then latch done until reset.
  always_comb begin
    pu_cnt_d       = pu_cnt_q;
    powerup_done_d = powerup_done_q;
    if (!powerup_done_q) begin
      pu_cnt_d       = (&pu_cnt_q) ? pu_cnt_q : pu_cnt_q + CNT_W'(1);
      powerup_done_d = limit_reached(32'(pu_cnt_q), POWERUP_CYCLES);
    end
  end

  // Stagger arbiter: lowest requesting index wins once the spacing window is clear.
  always_comb begin
    grant      = (stag_cnt_q == '0) ? (wake_req & (~wake_req + NUM_CH'(1))) : '0;
    stag_cnt_d = stag_cnt_q;
    if (|grant) begin
      stag_cnt_d = C_STAG_LOAD;
    end else if (stag_cnt_q != '0) begin
      stag_cnt_d = stag_cnt_q - CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwm_amp_channel #(
      .CNT_W         (CNT_W),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .DRAIN_CYCLES  (DRAIN_CYCLES),
      .IDLE_CYCLES   (IDLE_CYCLES)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_en_req       (ch_en_req[gi]),
      .i_activity     (ch_activity[gi]),
      .i_force_off    (force_off),
      .i_powerup_done (powerup_done_q),
      .i_grant        (grant[gi]),
      .o_wake_req     (wake_req[gi]),
      .o_sd_d         (sd_d[gi]),
      .o_ready_d      (ready_d[gi])
    );
  end

  // Global counters and output pins; reset drops every pin without a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pu_cnt_q       <= '0;
      powerup_done_q <= 1'b0;
      stag_cnt_q     <= '0;
      amp_sd_q       <= '0;
      ch_ready_q     <= '0;
    end else begin
      pu_cnt_q       <= pu_cnt_d;
      powerup_done_q <= powerup_done_d;
      stag_cnt_q     <= stag_cnt_d;
      amp_sd_q       <= sd_d;
      ch_ready_q     <= ready_d;
    end
  end

  assign amp_sd       = amp_sd_q;
  assign ch_ready     = ch_ready_q;
  assign powerup_done = powerup_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_amp_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pwm_amp_sequencer                                      |
// | Purpose  : Self-checking bench: directed table, hand sequences and   |
// |            random traffic against a timestamp-based reference model. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_pwm_amp_sequencer;

  localparam int NUM_CH  = 2;
  localparam int POWERUP = 16;
  localparam int STAGGER = 4;
  localparam int SETTLE  = 8;
  localparam int DRAIN   = 3;
  localparam int IDLE    = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_en_req = '0;
  logic [NUM_CH-1:0] ch_activity = '0;
  logic              force_off = 1'b0;
  logic [NUM_CH-1:0] amp_sd;
  logic [NUM_CH-1:0] ch_ready;
  logic              powerup_done;

  int errors = 0;
  int checks = 0;

  // Reference model: n counts clock edges since reset release; phases end at
  // absolute edge numbers (deadlines). mode 0=off 1=waking 2=on 3=draining.
  int n;
  int m_mode[NUM_CH];
  int m_dl[NUM_CH];
  int m_idle_dl[NUM_CH];
  bit m_armed[NUM_CH];
  int m_grant_ok;

  typedef struct {
    int        edge_n;
    logic [1:0] en;
    logic [1:0] exp_sd;
    logic [1:0] exp_rdy;
    logic      exp_done;
  } vec_t;
  vec_t vecs[15];

  always #5 clk = ~clk;

  pwm_amp_sequencer #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (20),
    .POWERUP_CYCLES (POWERUP),
    .STAGGER_CYCLES (STAGGER),
    .SETTLE_CYCLES  (SETTLE),
    .DRAIN_CYCLES   (DRAIN),
    .IDLE_CYCLES    (IDLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_en_req    (ch_en_req),
    .ch_activity  (ch_activity),
    .force_off    (force_off),
    .amp_sd       (amp_sd),
    .ch_ready     (ch_ready),
    .powerup_done (powerup_done)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, n, got, exp);
    end
  endtask

  function automatic void m_reset();
    n = 0;
    m_grant_ok = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i]    = 0;
      m_dl[i]      = 0;
      m_idle_dl[i] = 0;
      m_armed[i]   = 1'b1;
    end
  endfunction

  function automatic void m_step(input logic [1:0] en, input logic [1:0] act, input logic frc);
    bit done_before;
    bit granted;
    n++;
    done_before = ((n - 1) >= POWERUP);
    granted = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (m_mode[i])
        0: if (!granted && done_before && en[i] && m_armed[i] && !frc && n >= m_grant_ok) begin
             m_mode[i] = 1;
             m_dl[i] = n + SETTLE;
             granted = 1'b1;
             m_grant_ok = n + STAGGER;
           end
        1: if (frc || !en[i]) m_mode[i] = 0;
           else if (n >= m_dl[i]) begin
             m_mode[i] = 2;
             m_idle_dl[i] = n + IDLE;
           end
        2: if (frc) m_mode[i] = 0;
           else if (!en[i]) begin
             m_mode[i] = 3;
             m_dl[i] = n + DRAIN;
           end else if (act[i]) m_idle_dl[i] = n + IDLE;
           else if (IDLE != 0 && n >= m_idle_dl[i]) begin
             m_mode[i] = 3;
             m_dl[i] = n + DRAIN;
             m_armed[i] = 1'b0;
           end
        default: if (frc || n >= m_dl[i]) m_mode[i] = 0;
      endcase
      if (act[i]) m_armed[i] = 1'b1;
    end
  endfunction

  function automatic logic [4:0] m_out();
    logic [1:0] sd;
    logic [1:0] rdy;
    for (int i = 0; i < NUM_CH; i++) begin
      sd[i]  = (m_mode[i] != 0);
      rdy[i] = (m_mode[i] == 2);
    end
    return {sd, rdy, (n >= POWERUP)};
  endfunction

  // One clock: advance the model at the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) m_step(ch_en_req, ch_activity, force_off);
    #1;
    if (!rst_n) check("reset_out", {3'b0, amp_sd, ch_ready, powerup_done}, 8'd0);
    else        check("model", {3'b0, amp_sd, ch_ready, powerup_done}, {3'b0, m_out()});
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic pulse_act(input logic [1:0] a);
    ch_activity = a;
    tick();
    ch_activity = '0;
  endtask

  task automatic chk_pins(input string name, input logic [1:0] sd, input logic [1:0] rdy);
    check({name, "_sd"}, {6'b0, amp_sd}, {6'b0, sd});
    check({name, "_rdy"}, {6'b0, ch_ready}, {6'b0, rdy});
  endtask

  initial begin
    // Power-up, stagger, settle and idle shutdown with both requests held.
    vecs[0]  = '{15, 2'b11, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{16, 2'b11, 2'b00, 2'b00, 1'b1};
    vecs[2]  = '{17, 2'b11, 2'b01, 2'b00, 1'b1};
    vecs[3]  = '{20, 2'b11, 2'b01, 2'b00, 1'b1};
    vecs[4]  = '{21, 2'b11, 2'b11, 2'b00, 1'b1};
    vecs[5]  = '{24, 2'b11, 2'b11, 2'b00, 1'b1};
    vecs[6]  = '{25, 2'b11, 2'b11, 2'b01, 1'b1};
    vecs[7]  = '{28, 2'b11, 2'b11, 2'b01, 1'b1};
    vecs[8]  = '{29, 2'b11, 2'b11, 2'b11, 1'b1};
    vecs[9]  = '{44, 2'b11, 2'b11, 2'b11, 1'b1};
    vecs[10] = '{45, 2'b11, 2'b11, 2'b10, 1'b1};
    vecs[11] = '{47, 2'b11, 2'b11, 2'b10, 1'b1};
    vecs[12] = '{48, 2'b11, 2'b10, 2'b10, 1'b1};
    vecs[13] = '{49, 2'b11, 2'b10, 2'b00, 1'b1};
    vecs[14] = '{52, 2'b11, 2'b00, 2'b00, 1'b1};

    m_reset();
    rst_n = 1'b0;
    ch_en_req = 2'b11;
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;

    for (int v = 0; v < 15; v++) begin
      ch_en_req = vecs[v].en;
      run_to(vecs[v].edge_n);
      chk_pins("vec", vecs[v].exp_sd, vecs[v].exp_rdy);
      check("vec_done", {7'b0, powerup_done}, {7'b0, vecs[v].exp_done});
    end

    // Re-arm after idle shutdown: activity pulse, then grant, then settle again.
    run_to(54);
    pulse_act(2'b01);
    chk_pins("rearm_armed", 2'b00, 2'b00);
    tick();
    chk_pins("rearm_wake", 2'b01, 2'b00);
    run_to(63);
    chk_pins("rearm_settle", 2'b01, 2'b00);
    tick();
    chk_pins("rearm_ready", 2'b01, 2'b01);

    // Activity on the exact timeout edge keeps the channel ready and restarts the timer.
    run_to(83);
    pulse_act(2'b01);
    chk_pins("coinc_hold", 2'b01, 2'b01);
    run_to(103);
    chk_pins("coinc_restart", 2'b01, 2'b01);
    tick();
    chk_pins("coinc_timeout", 2'b01, 2'b00);

    // Request drop during settle at count 5.
    run_to(109);
    pulse_act(2'b01);
    run_to(116);
    chk_pins("drop_wake", 2'b01, 2'b00);
    ch_en_req = 2'b10;
    tick();
    chk_pins("drop_off", 2'b00, 2'b00);
    run_to(120);
    chk_pins("drop_noready", 2'b00, 2'b00);

    // force_off with both channels on, then staggered re-wake.
    ch_en_req = 2'b11;
    pulse_act(2'b11);
    run_to(139);
    chk_pins("force_pre", 2'b11, 2'b11);
    force_off = 1'b1;
    tick();
    force_off = 1'b0;
    chk_pins("force_off", 2'b00, 2'b00);
    tick();
    chk_pins("force_wake0", 2'b01, 2'b00);
    run_to(144);
    chk_pins("force_gap", 2'b01, 2'b00);
    tick();
    chk_pins("force_wake1", 2'b11, 2'b00);

    // Asynchronous reset while a channel is on.
    run_to(152);
    chk_pins("async_pre", 2'b11, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {3'b0, amp_sd, ch_ready, powerup_done}, 8'd0);
    m_reset();
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(39) == 0) begin
        int b;
        b = int'($urandom_range(NUM_CH - 1));
        ch_en_req[b] = ~ch_en_req[b];
      end
      ch_activity = {($urandom_range(19) == 0), ($urandom_range(19) == 0)};
      force_off = ($urandom_range(63) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
